// File: rtl/serial_adder_n_if.sv
// serial_adder_n_if: start/done handshake and operand/result bus for serial_adder_n.
//   master: drives start, a, b, cin, sub; observes ready, busy, done, sum, cout, ovf
//   slave : the adder side of the same signals
interface serial_adder_n_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             ready;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output start, a, b, cin, sub,
        input  ready, busy, done, sum, cout, ovf
    );

    modport slave (
        input  start, a, b, cin, sub,
        output ready, busy, done, sum, cout, ovf
    );
endinterface

// File: rtl/serial_adder_n.sv
// serial_adder_n: bit-serial add/subtract, LSB first, one bit per clock through a
// single full-adder slice and a carry flop. Result is presented with a one-cycle
// done pulse, WIDTH+1 cycles after the accepting start edge.
//   clk  : rising-edge clock
//   clr  : asynchronous active-low reset
//   bus  : serial_adder_n_if.slave (start/a/b/cin/sub in; ready/busy/done/sum/cout/ovf out)
// Optional feature: define SERIAL_ADDER_OVF_EN to build the signed-overflow flag;
// otherwise ovf is tied to 0.
module serial_adder_n #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             clr,
    serial_adder_n_if.slave  bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             s_bit, c_nxt;
`ifdef SERIAL_ADDER_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    // Single full-adder slice.
    assign s_bit = a_q[0] ^ b_q[0] ^ carry_q;
    assign c_nxt = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
        ovf_d   = ovf_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    // Subtraction is A + ~B + ~borrow; once B and the carry are
                    // pre-inverted here the slice needs no knowledge of sub.
                    a_d     = bus.a;
                    b_d     = bus.sub ? ~bus.b : bus.b;
                    carry_d = bus.cin ^ bus.sub;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end else if (state_q == DONE) begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                res_d   = {s_bit, res_q[WIDTH-1:1]};
                carry_d = c_nxt;
                if (cnt_q == LAST) begin
                    // Results are registered on the edge entering DONE so they are
                    // valid in the same cycle as the done pulse.
                    sum_d   = {s_bit, res_q[WIDTH-1:1]};
                    cout_d  = c_nxt;
`ifdef SERIAL_ADDER_OVF_EN
                    // carry_q here is the carry into the MSB.
                    ovf_d   = carry_q ^ c_nxt;
`endif
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    // Status outputs decode the state register only.
    assign bus.ready = (state_q != SHIFT);
    assign bus.busy  = (state_q == SHIFT);
    assign bus.done  = (state_q == DONE);
    assign bus.sum   = sum_q;
    assign bus.cout  = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
    assign bus.ovf   = ovf_q;
`else
    assign bus.ovf   = 1'b0;
`endif
endmodule

// File: tb/tb_serial_adder_n.sv
module tb_serial_adder_n;
    logic clk = 1'b0;
    logic clr;
    always #5 clk = ~clk;

    serial_adder_n_if #(.WIDTH(2))  if2();
    serial_adder_n_if #(.WIDTH(8))  if8();
    serial_adder_n_if #(.WIDTH(64)) if64();

    serial_adder_n #(.WIDTH(2))  dut2  (.clk(clk), .clr(clr), .bus(if2.slave));
    serial_adder_n #(.WIDTH(8))  dut8  (.clk(clk), .clr(clr), .bus(if8.slave));
    serial_adder_n #(.WIDTH(64)) dut64 (.clk(clk), .clr(clr), .bus(if64.slave));

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] a, b;
        logic       cin, sub;
        logic [7:0] s;
        logic       co, ov;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic exp_ovf(input logic ov);
`ifdef SERIAL_ADDER_OVF_EN
        return ov;
`else
        return 1'b0;
`endif
    endfunction

    // Reference: plain integer arithmetic in a wide signed domain.
    task automatic ref_op(input int w, input logic [63:0] a, input logic [63:0] b,
                          input logic ci, input logic sb,
                          output logic [63:0] s, output logic co, output logic ov);
        logic signed [67:0] mask, half, ua, ub, sa, sbv, ru, rs, c;
        mask = (68'sd1 <<< w) - 68'sd1;
        half = 68'sd1 <<< (w - 1);
        ua   = {4'b0, a} & mask;
        ub   = {4'b0, b} & mask;
        sa   = (ua ^ half) - half;
        sbv  = (ub ^ half) - half;
        c    = ci ? 68'sd1 : 68'sd0;
        if (!sb) begin
            ru = ua + ub + c;
            rs = sa + sbv + c;
            co = ru[w];
        end else begin
            ru = ua - ub - c;
            rs = sa - sbv - c;
            co = (ru >= 68'sd0);
        end
        s  = ru[63:0] & mask[63:0];
        ov = (rs >= half) || (rs < -half);
    endtask

    task automatic set_in(input int w, input logic st, input logic [63:0] a,
                          input logic [63:0] b, input logic ci, input logic sb);
        case (w)
            2:  begin if2.start = st;  if2.a = a[1:0];  if2.b = b[1:0];  if2.cin = ci;  if2.sub = sb;  end
            8:  begin if8.start = st;  if8.a = a[7:0];  if8.b = b[7:0];  if8.cin = ci;  if8.sub = sb;  end
            default: begin if64.start = st; if64.a = a; if64.b = b; if64.cin = ci; if64.sub = sb; end
        endcase
    endtask

    task automatic get_out(input int w, output logic [63:0] s, output logic co, output logic ov,
                           output logic dn, output logic rdy, output logic bsy);
        case (w)
            2:  begin s = {62'b0, if2.sum}; co = if2.cout; ov = if2.ovf; dn = if2.done; rdy = if2.ready; bsy = if2.busy; end
            8:  begin s = {56'b0, if8.sum}; co = if8.cout; ov = if8.ovf; dn = if8.done; rdy = if8.ready; bsy = if8.busy; end
            default: begin s = if64.sum; co = if64.cout; ov = if64.ovf; dn = if64.done; rdy = if64.ready; bsy = if64.busy; end
        endcase
    endtask

    // Counts falling edges until done is seen; bounded.
    task automatic wait_done(input int w, output int n);
        logic [63:0] s;
        logic co, ov, dn, rdy, bsy;
        n  = 0;
        dn = 1'b0;
        while (!dn && n < 200) begin
            @(negedge clk);
            n++;
            get_out(w, s, co, ov, dn, rdy, bsy);
        end
        if (!dn) chk("done_timeout", 64'd0, 64'd1);
    endtask

    task automatic run_op(input int w, input logic [63:0] a, input logic [63:0] b,
                          input logic ci, input logic sb,
                          output logic [63:0] s, output logic co, output logic ov, output int n);
        logic dn, rdy, bsy;
        @(negedge clk);
        set_in(w, 1'b1, a, b, ci, sb);
        @(posedge clk);
        #1 set_in(w, 1'b0, a, b, ci, sb);
        wait_done(w, n);
        get_out(w, s, co, ov, dn, rdy, bsy);
        chk("done_ready", {63'b0, rdy}, 64'd1);
        chk("done_busy",  {63'b0, bsy}, 64'd0);
    endtask

    initial begin
        vec_t        tbl[7];
        logic [63:0] s, es, ra, rb;
        logic        co, ov, dn, rdy, bsy, eco, eov, rc, rsb;
        int          n;
        int          widths[3];

        tbl[0] = '{8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0, 1'b1};
        tbl[1] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
        tbl[2] = '{8'h00, 8'h00, 1'b1, 1'b0, 8'h01, 1'b0, 1'b0};
        tbl[3] = '{8'h10, 8'h20, 1'b0, 1'b1, 8'hF0, 1'b0, 1'b0};
        tbl[4] = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1};
        tbl[5] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
        tbl[6] = '{8'h05, 8'h05, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0};
        widths = '{2, 8, 64};

        clr = 1'b0;
        set_in(2, 1'b0, 64'd0, 64'd0, 1'b0, 1'b0);
        set_in(8, 1'b0, 64'd0, 64'd0, 1'b0, 1'b0);
        set_in(64, 1'b0, 64'd0, 64'd0, 1'b0, 1'b0);
        #12;
        get_out(8, s, co, ov, dn, rdy, bsy);
        chk("rst_sum", s, 64'd0);
        chk("rst_flags", {58'b0, co, ov, dn, rdy, bsy, 1'b0}, {58'b0, 6'b000100});
        @(negedge clk) clr = 1'b1;

        // Directed table on WIDTH=8.
        foreach (tbl[i]) begin
            run_op(8, {56'b0, tbl[i].a}, {56'b0, tbl[i].b}, tbl[i].cin, tbl[i].sub, s, co, ov, n);
            chk($sformatf("tbl%0d_lat", i), n, 64'd9);
            chk($sformatf("tbl%0d_sum", i), s, {56'b0, tbl[i].s});
            chk($sformatf("tbl%0d_cout", i), {63'b0, co}, {63'b0, tbl[i].co});
            chk($sformatf("tbl%0d_ovf", i), {63'b0, ov}, {63'b0, exp_ovf(tbl[i].ov)});
        end

        // start during SHIFT is ignored.
        @(negedge clk) set_in(8, 1'b1, 64'h5A, 64'h3C, 1'b0, 1'b0);
        @(posedge clk);
        #1 set_in(8, 1'b0, 64'h5A, 64'h3C, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        get_out(8, s, co, ov, dn, rdy, bsy);
        chk("shift_busy",  {62'b0, bsy, rdy}, 64'b10);
        set_in(8, 1'b1, 64'hFF, 64'hFF, 1'b1, 1'b1);
        @(posedge clk);
        #1 set_in(8, 1'b0, 64'hFF, 64'hFF, 1'b1, 1'b1);
        wait_done(8, n);
        get_out(8, s, co, ov, dn, rdy, bsy);
        chk("ignore_lat", n, 64'd7);
        chk("ignore_sum", s, 64'h96);

        // start held high through DONE: back-to-back, operands re-sampled at DONE.
        @(negedge clk) set_in(8, 1'b1, 64'h01, 64'h02, 1'b0, 1'b0);
        @(posedge clk);
        #1 set_in(8, 1'b1, 64'h10, 64'h20, 1'b0, 1'b0);
        wait_done(8, n);
        get_out(8, s, co, ov, dn, rdy, bsy);
        chk("b2b_lat1", n, 64'd9);
        chk("b2b_sum1", s, 64'h03);
        @(posedge clk);
        #1 set_in(8, 1'b0, 64'h10, 64'h20, 1'b0, 1'b0);
        @(negedge clk);
        get_out(8, s, co, ov, dn, rdy, bsy);
        chk("b2b_busy", {63'b0, bsy}, 64'd1);
        chk("b2b_hold", s, 64'h03);
        wait_done(8, n);
        get_out(8, s, co, ov, dn, rdy, bsy);
        chk("b2b_lat2", n + 1, 64'd9);
        chk("b2b_sum2", s, 64'h30);

        // Reset asserted in the 4th SHIFT cycle.
        @(negedge clk) set_in(8, 1'b1, 64'h11, 64'h22, 1'b0, 1'b0);
        @(posedge clk);
        #1 set_in(8, 1'b0, 64'h11, 64'h22, 1'b0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        @(posedge clk);
        #2 clr = 1'b0;
        #1 get_out(8, s, co, ov, dn, rdy, bsy);
        chk("abort_sum", s, 64'd0);
        chk("abort_flags", {58'b0, co, ov, dn, rdy, bsy, 1'b0}, {58'b0, 6'b000100});
        @(negedge clk) clr = 1'b1;
        run_op(8, 64'h03, 64'h04, 1'b0, 1'b0, s, co, ov, n);
        chk("post_rst_lat", n, 64'd9);
        chk("post_rst_sum", s, 64'h07);

        // Random regressions for WIDTH = 2, 8, 64.
        foreach (widths[k]) begin
            for (int i = 0; i < 20; i++) begin
                ra  = {$urandom, $urandom};
                rb  = {$urandom, $urandom};
                rc  = 1'($urandom_range(1));
                rsb = 1'($urandom_range(1));
                ref_op(widths[k], ra, rb, rc, rsb, es, eco, eov);
                run_op(widths[k], ra, rb, rc, rsb, s, co, ov, n);
                chk($sformatf("w%0d_r%0d_lat", widths[k], i), n, 64'(widths[k] + 1));
                chk($sformatf("w%0d_r%0d_sum", widths[k], i), s, es);
                chk($sformatf("w%0d_r%0d_cout", widths[k], i), {63'b0, co}, {63'b0, eco});
                chk($sformatf("w%0d_r%0d_ovf", widths[k], i), {63'b0, ov}, {63'b0, exp_ovf(eov)});
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
